uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART sender between NREQ byte producers.
// Round-robin grant, one-cycle enable/ack pulses, then a guard window in which
// sender_ready is ignored, then a wait for sender_ready before the next grant.
// Optional build macro UART_TX_ARB_PRIO_EN: requester 0 gets strict priority,
// round-robin applies among requesters 1..NREQ-1 only.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]              req_ack,
    output logic [DATA_WIDTH-1:0]        sender_data,
    output logic                         sender_enable,
    input  logic                         sender_ready,
    output logic [$clog2(NREQ)-1:0]      grant_id,
    output logic                         busy
);

    localparam int unsigned IdW  = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StGuard, StWait} state_e;

    state_e                state_q, state_d;
    logic [IdW-1:0]        ptr_q, ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]       ack_d;
    logic                  en_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic [IdW-1:0]        gid_d;

    logic [NREQ-1:0]       rr_mask;
    logic [IdW-1:0]        winner;
    logic [IdW-1:0]        idx;
    logic                  found;
    logic [DATA_WIDTH-1:0] win_data;

    // Winner search: first valid requester from ptr+1 upward, wrapping.
    always_comb begin
        rr_mask  = req_valid;
        winner   = '0;
        idx      = '0;
        found    = 1'b0;
        win_data = '0;
`ifdef UART_TX_ARB_PRIO_EN
        rr_mask[0] = 1'b0;
`endif
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = IdW'((32'(ptr_q) + i) % NREQ);
            if (!found && rr_mask[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
`ifdef UART_TX_ARB_PRIO_EN
        // Requester 0 overrides the rotation whenever it is asking.
        if (req_valid[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == IdW'(i)) begin
                win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        en_d    = 1'b0;
        data_d  = sender_data;
        gid_d   = grant_id;
        unique case (state_q)
            StIdle: begin
                if (sender_ready && found) begin
                    ack_d[winner] = 1'b1;
                    en_d          = 1'b1;
                    data_d        = win_data;
                    gid_d         = winner;
`ifdef UART_TX_ARB_PRIO_EN
                    if (winner != '0) begin
                        ptr_d = winner;
                    end
`else
                    ptr_d = winner;
`endif
                    cnt_d   = CntW'(GUARD_CYCLES);
                    state_d = StGuard;
                end
            end
            StGuard: begin
                // sender_ready may still be stale here; leave when the count expires.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CntW'(1)) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (sender_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            ptr_q         <= IdW'(NREQ - 1);
            cnt_q         <= '0;
            req_ack       <= '0;
            sender_enable <= 1'b0;
            sender_data   <= '0;
            grant_id      <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            req_ack       <= ack_d;
            sender_enable <= en_d;
            sender_data   <= data_d;
            grant_id      <= gid_d;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model, a sender model
// with configurable stale/busy ready behaviour, directed scenarios and random traffic.
module tb_uart_tx_arbiter;

    localparam int NREQ  = 3;
    localparam int DW    = 8;
    localparam int GUARD = 2;
`ifdef UART_TX_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ack;
    logic [DW-1:0]        sender_data;
    logic                 sender_enable;
    logic                 sender_ready;
    logic [1:0]           grant_id;
    logic                 busy;

    uart_tx_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .GUARD_CYCLES(GUARD)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .sender_data(sender_data), .sender_enable(sender_enable),
        .sender_ready(sender_ready), .grant_id(grant_id), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: ptr, idle flag, remaining cycles where ready is ignored.
    int             m_ptr  = NREQ - 1;
    bit             m_idle = 1'b1;
    int             m_ign  = 0;
    logic           exp_en   = 1'b0;
    logic [NREQ-1:0] exp_ack = '0;
    logic [DW-1:0]  exp_data = '0;
    logic [1:0]     exp_gid  = '0;
    logic           exp_busy = 1'b0;

    // Sender model configuration and state.
    int s_stale_cfg = 0;
    int s_busy_cfg  = 3;
    int s_stale_left = 0;
    int s_busy_left  = 0;
    bit s_force_low  = 1'b0;
    bit s_stale_now  = 1'b0;
    int min_gap      = 0;
    int last_en_cyc  = -1000;

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        if (PRIO && v[0]) return 0;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (ptr + k) % NREQ;
            if (!(PRIO && c == 0) && v[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (RST) begin
            m_ptr = NREQ - 1; m_idle = 1'b1; m_ign = 0;
            exp_en = 1'b0; exp_ack = '0; exp_data = '0; exp_gid = '0;
        end else begin
            exp_en = 1'b0;
            exp_ack = '0;
            if (m_idle) begin
                if (sender_ready && req_valid != '0) begin
                    w = pick(req_valid, m_ptr);
                    exp_en   = 1'b1;
                    exp_ack  = NREQ'(1 << w);
                    exp_data = DW'(req_data >> (w * DW));
                    exp_gid  = 2'(w);
                    if (!(PRIO && w == 0)) m_ptr = w;
                    m_idle = 1'b0;
                    m_ign  = GUARD;
                end
            end else if (m_ign > 0) begin
                m_ign--;
            end else if (sender_ready) begin
                m_idle = 1'b1;
            end
        end
        exp_busy = !m_idle;
    endtask

    task automatic check_outputs();
        total++;
        if (sender_enable !== exp_en || req_ack !== exp_ack || sender_data !== exp_data ||
            grant_id !== exp_gid || busy !== exp_busy) begin
            bad++;
            $display("FAIL outputs cyc=%0d got en=%b ack=%b data=%h gid=%0d busy=%b want en=%b ack=%b data=%h gid=%0d busy=%b",
                     cyc, sender_enable, req_ack, sender_data, grant_id, busy,
                     exp_en, exp_ack, exp_data, exp_gid, exp_busy);
        end
    endtask

    // Sender model: a pulse while the sender is still busy is a protocol violation.
    task automatic sender_update();
        bit nr;
        if (sender_enable === 1'b1) begin
            total++;
            if (s_stale_left > 0 || s_busy_left > 0 || (cyc - last_en_cyc) < min_gap) begin
                bad++;
                $display("FAIL sender_protocol cyc=%0d got enable while busy (stale=%0d busy=%0d gap=%0d) want idle sender, gap>=%0d",
                         cyc, s_stale_left, s_busy_left, cyc - last_en_cyc, min_gap);
            end
            s_stale_left = s_stale_cfg;
            s_busy_left  = s_busy_cfg;
            last_en_cyc  = cyc;
        end
        s_stale_now = 1'b0;
        if (s_stale_left > 0) begin
            s_stale_left--; nr = 1'b1; s_stale_now = 1'b1;
        end else if (s_busy_left > 0) begin
            s_busy_left--; nr = 1'b0;
        end else begin
            nr = 1'b1;
        end
        sender_ready = nr && !s_force_low;
    endtask

    task automatic step();
        @(posedge CLK);
        cyc++;
        model_step();
        #1;
        check_outputs();
        sender_update();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
    endtask

    task automatic settle(input int n);
        req_valid = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    logic [DW-1:0] rot_exp [4];
    logic [DW-1:0] rot_got [4];

    initial begin
        int n_en, n_ack, got;
        RST = 1'b1; req_valid = '0; req_data = '0; sender_ready = 1'b1;
`ifdef UART_TX_ARB_PRIO_EN
        rot_exp = '{8'h10, 8'h10, 8'h10, 8'h10};
`else
        rot_exp = '{8'h10, 8'h20, 8'h30, 8'h10};
`endif
        do_reset();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_enable", 32'(sender_enable), 0);
        chk("reset_ack", 32'(req_ack), 0);
        chk("reset_gid", 32'(grant_id), 0);
        chk("reset_data", 32'(sender_data), 0);

        // Single request: one-cycle grant latency.
        req_valid = 3'b001; req_data = 24'h000041;
        step();
        chk("first_enable", 32'(sender_enable), 1);
        chk("first_data", 32'(sender_data), 32'h41);
        chk("first_ack", 32'(req_ack), 32'b001);
        chk("first_gid", 32'(grant_id), 0);
        chk("first_busy", 32'(busy), 1);
        req_valid = '0;
        step();
        chk("first_enable_drop", 32'(sender_enable), 0);
        settle(12);

        // All valid continuously: rotation order and spacing.
        s_stale_cfg = 0; s_busy_cfg = 10; min_gap = 10;
        do_reset();
        req_valid = 3'b111; req_data = 24'h302010;
        got = 0;
        for (int k = 0; k < 200 && got < 4; k++) begin
            step();
            if (sender_enable === 1'b1) begin
                rot_got[got] = sender_data;
                got++;
            end
        end
        chk("rotation_count", 32'(got), 4);
        for (int k = 0; k < 4 && k < got; k++) chk($sformatf("rotation_%0d", k), 32'(rot_got[k]), 32'(rot_exp[k]));
        min_gap = 0;
        settle(15);

        // Ready held low: no grant during the hold, grant one cycle after ready rises.
        s_busy_cfg = 3;
        s_force_low = 1'b1;
        do_reset();
        req_valid = 3'b111;
        n_en = 0; n_ack = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (sender_enable === 1'b1) n_en++;
            if (req_ack !== '0) n_ack++;
        end
        chk("hold_enables", 32'(n_en), 0);
        chk("hold_acks", 32'(n_ack), 0);
        chk("hold_busy", 32'(busy), 0);
        s_force_low = 1'b0; sender_ready = 1'b1;
        step();
        chk("hold_release_enable", 32'(sender_enable), 1);
        chk("hold_release_ack", 32'(req_ack), 32'b001);
        settle(10);

        // Stale ready for one cycle after enable: the guard window must cover it.
        s_stale_cfg = 1; s_busy_cfg = 4;
        req_valid = 3'b111;
        n_en = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (sender_enable === 1'b1) n_en++;
        end
        chk("stale_activity", 32'(n_en >= 3), 1);
        settle(10);

        // Reset while waiting for the sender.
        s_stale_cfg = 0; s_busy_cfg = 3;
        req_valid = 3'b100; req_data = 24'h5a0000;
        got = 0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            step();
            if (sender_enable === 1'b1) got = 1;
        end
        chk("wait_grant_seen", 32'(got), 1);
        chk("wait_grant_gid", 32'(grant_id), 2);
        req_valid = '0; s_force_low = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk("wait_busy", 32'(busy), 1);
        RST = 1'b1;
        step();
        chk("rst_wait_busy", 32'(busy), 0);
        chk("rst_wait_gid", 32'(grant_id), 0);
        chk("rst_wait_ack", 32'(req_ack), 0);
        RST = 1'b0; s_force_low = 1'b0; sender_ready = 1'b1;
        req_valid = 3'b010; req_data = 24'h00_77_00;
        step();
        chk("rst_regrant_ack", 32'(req_ack), 32'b010);
        chk("rst_regrant_gid", 32'(grant_id), 1);
        chk("rst_regrant_data", 32'(sender_data), 32'h77);
        settle(10);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) begin
                s_stale_cfg = $urandom_range(0, GUARD - 1);
                s_busy_cfg  = $urandom_range(0, 6);
            end
            if ($urandom_range(0, 39) == 0) s_force_low = !s_force_low;
            RST = (!s_stale_now && $urandom_range(0, 149) == 0);
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i] === 1'b1) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_data[i*DW +: DW] = DW'($urandom);
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom);
                end else if (req_valid[i] && $urandom_range(0, 49) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        RST = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
